// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response and decode-side handshake bundle for fetch_queue
interface fetch_queue_if #(parameter int XLEN = 64);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_valid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_valid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner issuing one imem read at a time into a DEPTH-entry {pc, inst} FIFO
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic            pending, drop;
  logic [AW-1:0]   head, tail;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     word_mem [DEPTH];
  logic            redirect, resp, push, pop, issue, has_data;
  always_comb begin
    redirect = bus.redirect_valid;
    has_data = |count;
    resp     = bus.imem_valid & pending;
    push     = resp & !drop & !redirect;
    pop      = has_data & bus.inst_ready & !redirect;
    // pops are deliberately not credited so a full FIFO can never be overrun
    issue    = reset & !redirect & (!pending | resp) & ((int'(count) + int'(resp & !drop)) < DEPTH);
    bus.imem_req   = issue;
    bus.imem_addr  = fetch_pc;
    bus.inst_valid = has_data & !redirect;
    bus.inst       = has_data ? word_mem[head] : '0;
    bus.inst_pc    = has_data ? pc_mem[head] : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
      drop     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      fetch_pc <= redirect ? bus.redirect_pc : issue ? fetch_pc + XLEN'(4) : fetch_pc;
      req_pc   <= issue ? fetch_pc : req_pc;
      pending  <= issue | (pending & !resp);
      // a redirect with a request still in flight must discard that response later
      drop     <= redirect ? (pending & !resp) : (drop & !resp);
      head     <= redirect ? '0 : head + AW'(pop);
      tail     <= redirect ? '0 : tail + AW'(push);
      count    <= redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= req_pc;
      word_mem[tail] <= bus.imem_rdata;
    end
  end
endmodule
